// File: rtl/host_req_frontend.sv
// Host request frontend: host requests go into a first-word-fall-through FIFO and are
// offered to the scheduler over a valid/ready port. The block also counts accepted requests
// that have not completed yet. Back-end completions come back to the host as single-cycle
// done pulses.
module host_req_frontend #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 30,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Host request side
  input  logic                  in_valid,
  input  logic                  in_request_type,
  input  logic [ADDR_WIDTH-1:0] in_request_address,
  input  logic [DATA_WIDTH-1:0] in_request_data,
  output logic                  out_busy,
  // Scheduler side
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_type,
  output logic [ADDR_WIDTH-1:0] req_address,
  output logic [DATA_WIDTH-1:0] req_data,
  // Back-end completion side
  input  logic                  cpl_valid,
  input  logic                  cpl_type,
  input  logic [DATA_WIDTH-1:0] cpl_data,
  // Host completion side
  output logic                  write_done,
  output logic                  read_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  protocol_err
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW   = PtrW + 1;
  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EntryW = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [OccW-1:0] OccOne  = OccW'(1);
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);
  localparam logic [OutW-1:0] OutOne  = OutW'(1);
  localparam logic [OutW-1:0] OutMax  = OutW'(MAX_OUTSTANDING);

  // Storage and state
  logic [EntryW-1:0]     mem_q [DEPTH];
  logic [EntryW-1:0]     mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [OutW-1:0]       outst_q, outst_d;
  logic                  busy_q, busy_d;
  logic                  write_done_q, write_done_d;
  logic                  read_done_q, read_done_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  perr_q, perr_d;

  // Handshake qualifiers
  logic                  push;
  logic                  pop;
  logic                  cpl_ok;
  logic [EntryW-1:0]     head;

  // Decode the three events that happen this cycle
  always_comb begin
    push   = in_valid && !busy_q;
    pop    = (occ_q != '0) && req_ready;
    cpl_ok = cpl_valid && (outst_q != '0);
  end

  // FIFO storage write: the new entry lands at the write pointer
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {in_request_type, in_request_address, in_request_data};
    end
  end

  // Pointer and occupancy next state; pointers wrap naturally because DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    occ_d    = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase
  end

  // Outstanding count: push adds one and a valid completion removes one
  always_comb begin
    outst_d = outst_q;
    unique case ({push, cpl_ok})
      2'b10:   outst_d = outst_q + OutOne;
      2'b01:   outst_d = outst_q - OutOne;
      default: outst_d = outst_q;
    endcase
  end

  // Busy looks at next-state values so the host sees it before the overflowing edge
  always_comb begin
    busy_d = (occ_d == OccFull) || (outst_d == OutMax);
  end

  // Completion pulses, read data capture and the sticky protocol error flag
  always_comb begin
    write_done_d = cpl_ok && cpl_type;
    read_done_d  = cpl_ok && !cpl_type;
    data_out_d   = (cpl_ok && !cpl_type) ? cpl_data : data_out_q;
    perr_d       = perr_q
                 || (in_valid && busy_q)
                 || (cpl_valid && (outst_q == '0));
  end

  // FIFO storage registers; cleared so the req_* outputs read zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      outst_q      <= '0;
      busy_q       <= 1'b0;
      write_done_q <= 1'b0;
      read_done_q  <= 1'b0;
      data_out_q   <= '0;
      perr_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      outst_q      <= outst_d;
      busy_q       <= busy_d;
      write_done_q <= write_done_d;
      read_done_q  <= read_done_d;
      data_out_q   <= data_out_d;
      perr_q       <= perr_d;
    end
  end

  // The FIFO head is presented directly (first-word fall-through)
  always_comb begin
    head        = mem_q[rd_ptr_q];
    req_valid   = (occ_q != '0);
    req_type    = head[EntryW-1];
    req_address = head[EntryW-2 -: ADDR_WIDTH];
    req_data    = head[DATA_WIDTH-1:0];
  end

  assign out_busy     = busy_q;
  assign write_done   = write_done_q;
  assign read_done    = read_done_q;
  assign data_out     = data_out_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_host_req_frontend.sv
// Self-checking bench for host_req_frontend. A queue-based reference model tracks the expected
// FIFO contents, the outstanding count and the host-visible outputs.
module tb_host_req_frontend;

  localparam int DW    = 16;
  localparam int AW    = 30;
  localparam int DEPTH = 8;
  localparam int MAXO  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_request_type;
  logic [AW-1:0] in_request_address;
  logic [DW-1:0] in_request_data;
  logic          out_busy, req_valid, req_ready, req_type;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          cpl_valid, cpl_type;
  logic [DW-1:0] cpl_data;
  logic          write_done, read_done, protocol_err;
  logic [DW-1:0] data_out;

  host_req_frontend #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_request_type   (in_request_type),
    .in_request_address(in_request_address),
    .in_request_data   (in_request_data),
    .out_busy          (out_busy),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_type          (req_type),
    .req_address       (req_address),
    .req_data          (req_data),
    .cpl_valid         (cpl_valid),
    .cpl_type          (cpl_type),
    .cpl_data          (cpl_data),
    .write_done        (write_done),
    .read_done         (read_done),
    .data_out          (data_out),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic          t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q_m[$];
  int            outst_m;
  logic          busy_m, perr_m, wd_m, rd_m;
  logic [DW-1:0] dout_m;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    outst_m = 0;
    busy_m  = 1'b0;
    perr_m  = 1'b0;
    wd_m    = 1'b0;
    rd_m    = 1'b0;
    dout_m  = '0;
  endtask

  task automatic check_all();
    chk("req_valid", req_valid, q_m.size() != 0);
    if (q_m.size() != 0) begin
      chk("req_type", req_type, q_m[0].t);
      chk("req_address", req_address, q_m[0].a);
      chk("req_data", req_data, q_m[0].d);
    end
    chk("out_busy", out_busy, busy_m);
    chk("write_done", write_done, wd_m);
    chk("read_done", read_done, rd_m);
    chk("data_out", data_out, dout_m);
    chk("protocol_err", protocol_err, perr_m);
  endtask

  // One clock: apply the spec rules to the driven inputs, then compare after the edge
  task automatic step();
    bit   push, pop, cok;
    ent_t e;
    @(posedge clk);
    push = in_valid && !busy_m;
    pop  = (q_m.size() != 0) && req_ready;
    cok  = cpl_valid && (outst_m > 0);
    if ((in_valid && busy_m) || (cpl_valid && outst_m == 0)) perr_m = 1'b1;
    if (pop) void'(q_m.pop_front());
    if (push) begin
      e.t = in_request_type;
      e.a = in_request_address;
      e.d = in_request_data;
      q_m.push_back(e);
    end
    outst_m = outst_m + int'(push) - int'(cok);
    busy_m  = (q_m.size() == DEPTH) || (outst_m == MAXO);
    wd_m    = cok && cpl_type;
    rd_m    = cok && !cpl_type;
    if (cok && !cpl_type) dout_m = cpl_data;
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    in_valid           = 1'b0;
    in_request_type    = 1'b0;
    in_request_address = '0;
    in_request_data    = '0;
    req_ready          = 1'b0;
    cpl_valid          = 1'b0;
    cpl_type           = 1'b0;
    cpl_data           = '0;
  endtask

  task automatic rand_req();
    in_valid           = 1'b1;
    in_request_type    = 1'($urandom);
    in_request_address = AW'($urandom);
    in_request_data    = DW'($urandom);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_out_busy", out_busy, 0);
    chk("rst_done", {write_done, read_done}, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_data_out", data_out, 0);
    idle_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Single write
    in_valid = 1'b1; in_request_type = 1'b1;
    in_request_address = 30'h0000_1234; in_request_data = 16'hA5A5; req_ready = 1'b1;
    step();
    chk("wr_req_valid", req_valid, 1);
    chk("wr_req_address", req_address, 30'h0000_1234);
    chk("wr_req_data", req_data, 16'hA5A5);
    in_valid = 1'b0;
    step();
    chk("wr_req_valid_once", req_valid, 0);
    cpl_valid = 1'b1; cpl_type = 1'b1;
    step();
    chk("wr_done_pulse", write_done, 1);
    cpl_valid = 1'b0;
    step();
    chk("wr_done_once", write_done, 0);

    // Single read
    in_valid = 1'b1; in_request_type = 1'b0; in_request_address = 30'h3FFF_FFFF;
    step();
    chk("rd_req_address", req_address, 30'h3FFF_FFFF);
    in_valid = 1'b0;
    step();
    cpl_valid = 1'b1; cpl_type = 1'b0; cpl_data = 16'hBEEF;
    step();
    chk("rd_done_pulse", read_done, 1);
    chk("rd_data_out", data_out, 16'hBEEF);
    cpl_valid = 1'b0; cpl_data = 16'h0000;
    step();
    chk("rd_done_once", read_done, 0);
    chk("rd_data_hold", data_out, 16'hBEEF);

    // FIFO full, then a dropped request, then drain with wrap-around
    req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_req();
      step();
    end
    chk("full_busy", out_busy, 1);
    rand_req();
    step();
    chk("full_drop_perr", protocol_err, 1);
    in_valid  = 1'b0;
    req_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    chk("full_drained_busy", out_busy, 0);
    req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cpl_valid = 1'b1; cpl_type = 1'($urandom); cpl_data = DW'($urandom);
      step();
    end
    cpl_valid = 1'b0;
    step();

    // Outstanding limit
    req_ready = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      rand_req();
      step();
    end
    chk("outst_busy", out_busy, 1);
    in_valid = 1'b0; cpl_valid = 1'b1; cpl_type = 1'b1;
    step();
    chk("outst_free_one", out_busy, 0);
    cpl_valid = 1'b0;
    rand_req();
    step();
    chk("outst_busy_again", out_busy, 1);
    in_valid = 1'b0; cpl_valid = 1'b1;
    step();
    rand_req();
    step();
    chk("outst_push_cpl_same", out_busy, 0);
    in_valid = 1'b0;
    for (int i = 0; i < MAXO - 1; i++) begin
      cpl_valid = 1'b1; cpl_type = 1'($urandom); cpl_data = DW'($urandom);
      step();
    end
    cpl_valid = 1'b0;
    step();
    chk("outst_drained_busy", out_busy, 0);

    // Completion with nothing outstanding
    rst_pulse();
    cpl_valid = 1'b1; cpl_type = 1'b0; cpl_data = 16'h1357;
    step();
    chk("orphan_perr", protocol_err, 1);
    chk("orphan_no_done", {write_done, read_done}, 0);
    cpl_valid = 1'b0;
    step();

    // Reset mid-operation with 5 queued and 3 outstanding
    rst_pulse();
    for (int i = 0; i < DEPTH; i++) begin
      rand_req();
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpl_valid = 1'b1; cpl_type = 1'($urandom); cpl_data = DW'($urandom);
      step();
    end
    cpl_valid = 1'b0; req_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    req_ready = 1'b0;
    cpl_valid = 1'b1; cpl_type = 1'b0;
    #2;
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      cpl_valid = 1'b1; cpl_type = 1'($urandom); cpl_data = DW'($urandom);
      step();
      chk("post_rst_no_done", {write_done, read_done}, 0);
    end
    chk("post_rst_perr", protocol_err, 1);
    cpl_valid = 1'b0;

    // Randomized traffic against the model
    rst_pulse();
    for (int i = 0; i < 500; i++) begin
      if (($urandom_range(0, 99) < 60) && (!busy_m || $urandom_range(0, 19) == 0)) rand_req();
      else in_valid = 1'b0;
      req_ready = ($urandom_range(0, 99) < 55);
      cpl_valid = (outst_m > 0) && ($urandom_range(0, 99) < 45);
      cpl_type  = 1'($urandom);
      cpl_data  = DW'($urandom);
      step();
    end
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_req_frontend.md
Name: host_req_frontend

Overview:
Host-side responder for the controller request interface (in_valid / out_busy / in_request_* in; write_done / read_done / data_out out). It accepts host requests into a first-word-fall-through request FIFO, presents them to the scheduler over a valid/ready port, tracks outstanding requests, and returns back-end completions to the host as single-cycle done pulses. It is the first block the host/bench sees inside memory_controller.

Parameters:
DATA_WIDTH, 16, width of request write data and returned read data
ADDR_WIDTH, 30, width of request address
DEPTH, 8, request FIFO entries; power of 2, at least 2
MAX_OUTSTANDING, 32, maximum accepted-but-not-completed requests; at least DEPTH

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  host request strobe
in_request_type  in  1  1 = write, 0 = read
in_request_address  in  ADDR_WIDTH  request address
in_request_data  in  DATA_WIDTH  write data; ignored for reads
out_busy  out  1  host must not assert in_valid while high
req_valid  out  1  FIFO head valid toward scheduler
req_ready  in  1  scheduler takes head
req_type  out  1  head type
req_address  out  ADDR_WIDTH  head address
req_data  out  DATA_WIDTH  head data
cpl_valid  in  1  back-end completion pulse
cpl_type  in  1  completion type, 1 = write
cpl_data  in  DATA_WIDTH  read data; valid with cpl_valid when cpl_type = 0
write_done  out  1  one-cycle write completion to host
read_done  out  1  one-cycle read completion to host
data_out  out  DATA_WIDTH  read data, valid while read_done = 1
protocol_err  out  1  sticky error flag

Behaviour:
- Reset (rst_n = 0, asynchronous): FIFO pointers, occupancy, outstanding count and all outputs cleared to 0. req_valid = 0, out_busy = 0, protocol_err = 0. Reset mid-operation discards all queued and outstanding requests; no done pulses follow for them.
- Accept: push = in_valid && !out_busy at posedge. Entry holds {type, address, data}.
- Pop: pop = req_valid && req_ready. req_valid = (occupancy != 0). req_* are driven from the head entry (FWFT) and stay stable while req_valid && !req_ready.
- Latency: a request accepted at edge N appears on req_* with req_valid = 1 after edge N. There is no same-cycle bypass. Pushing and popping in the same cycle is legal when occupancy is at least 1; occupancy is then unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits and covers 0..DEPTH.
- Outstanding count: +1 on push, -1 on cpl_valid, unchanged when both occur in the same cycle. Width is clog2(MAX_OUTSTANDING+1).
- out_busy is a register loaded from next-state values: 1 iff next occupancy == DEPTH OR next outstanding == MAX_OUTSTANDING. The host therefore sees busy before the edge that would overflow either resource.
- in_valid while out_busy = 1: the request is dropped and protocol_err is set. Nothing else changes.
- Completion: cpl_valid at edge N sets write_done (cpl_type = 1) or read_done (cpl_type = 0) for exactly the cycle after edge N. On a read, data_out <= cpl_data. data_out holds its last value otherwise. At most one done pulse occurs per cycle. Back-to-back cpl_valid produces back-to-back pulses.
- cpl_valid with outstanding == 0: ignored (no done pulse, count stays 0) and protocol_err is set.
- protocol_err is cleared only by reset.

Test Plan:
- Single write: after reset, in_valid=1, type=1, addr=30'h0000_1234, data=16'hA5A5 for one cycle, req_ready=1 -> req_valid=1 for exactly one cycle with the same fields. Then cpl_valid=1, cpl_type=1 -> write_done=1 one cycle later. out_busy stays 0 throughout.
- Single read: type=0, addr=30'h3FFF_FFFF; then cpl_valid, cpl_type=0, cpl_data=16'hBEEF -> read_done=1 with data_out=16'hBEEF for exactly one cycle.
- FIFO full: req_ready=0, issue requests every cycle while !out_busy -> exactly 8 accepted, out_busy=1 after the 8th edge. Then raise req_ready -> the 8 requests pop in order, wrap-around is exercised, and out_busy falls.
- Outstanding limit: req_ready=1, no completions -> out_busy=1 after 32 accepts. One cpl_valid -> out_busy=0 and exactly one more accept is possible. A push coinciding with cpl_valid leaves the count unchanged.
- Protocol errors: in_valid while out_busy=1 -> FIFO unchanged, protocol_err=1. Separately after reset, cpl_valid with none outstanding -> no done pulse, protocol_err=1.
- Reset mid-operation: 5 queued and 3 outstanding, pulse rst_n low between edges -> req_valid, out_busy and the done signals go 0 immediately. Later cpl_valid pulses set protocol_err only.
